// File: rtl/instr_prefetch_reg.sv
// Instruction register with a small prefetch FIFO in front of the control unit.
// Words arrive under a valid/ready handshake, the oldest buffered word is presented
// as the current instruction (plus complement and opcode field), ld advances, flush
// discards everything.
// Optional build macro IR_PARITY_EN adds a per-entry even-parity bit, a perr_inject
// input to corrupt it on push, and a parity_err output for the head word.
module instr_prefetch_reg #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned OPC_BITS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           d,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       ld,
    input  logic                       flush,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           qinv,
    output logic                       q_valid,
    output logic [OPC_BITS-1:0]        opcode,
`ifdef IR_PARITY_EN
    input  logic                       perr_inject,
    output logic                       parity_err,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

`ifdef IR_PARITY_EN
    logic par_q [DEPTH];
    logic par_d [DEPTH];
`endif

    // Handshake flags depend only on registered count, never on in_valid/ld paths
    assign q_valid  = (count_q != '0);
    assign in_ready = (count_q != FullCnt);
    assign push     = in_valid & in_ready;
    assign pop      = ld & q_valid;

    // Next-state for pointers, count and storage; flush overrides any push/pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
`ifdef IR_PARITY_EN
        par_d    = par_q;
`endif
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = d;
`ifdef IR_PARITY_EN
                par_d[wr_ptr_q] = (^d) ^ perr_inject;
`endif
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array is not reset; validity is tracked by count alone
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
`ifdef IR_PARITY_EN
        par_q <= par_d;
`endif
    end

    // Head word presentation; forced to zero when nothing is buffered
    always_comb begin
        q      = q_valid ? mem_q[rd_ptr_q] : '0;
        qinv   = ~q;
        opcode = q[WIDTH-1 -: OPC_BITS];
`ifdef IR_PARITY_EN
        parity_err = q_valid & ((^q) != par_q[rd_ptr_q]);
`endif
    end

    assign count = count_q;

endmodule

// File: doc/instr_prefetch_reg.md
Name: instr_prefetch_reg

Overview:
- Parametrised instruction register with a small prefetch queue: the next generation of the 16-bit instruction register.
- Accepts instruction words from the fetch/memory side under a valid/ready handshake and buffers up to DEPTH words.
- Presents the oldest word, and its complement, to the control unit as the current instruction.
- The control unit advances with ld; a branch discards all buffered words with flush.

Parameters:
WIDTH, 16, instruction word width in bits (>=8)
DEPTH, 4, queue depth in words; power of two, >=2
OPC_BITS, 4, number of MSBs of the head word presented as opcode

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
d  input  WIDTH  instruction word from fetch
in_valid  input  1  d is valid this cycle
in_ready  output  1  queue can accept a word this cycle
ld  input  1  control unit consumes the current head word
flush  input  1  discard all buffered words
q  output  WIDTH  current instruction (head word)
qinv  output  WIDTH  bitwise complement of q
q_valid  output  1  q holds a valid instruction
opcode  output  OPC_BITS  q[WIDTH-1 -: OPC_BITS]
count  output  $clog2(DEPTH+1)  number of buffered words

Behaviour:
- Storage: DEPTH x WIDTH register array, write pointer wr_ptr, read pointer rd_ptr (log2(DEPTH) bits each, wrap naturally modulo DEPTH), count register.
- Reset (rst=1 at edge): wr_ptr=0, rd_ptr=0, count=0. Storage contents are not cleared.
- Outputs after reset: q_valid=0, q=0, qinv=all ones, opcode=0, in_ready=1, count=0.
- q_valid = (count!=0); in_ready = (count!=DEPTH). Both are combinational from registered count only; no combinational path from in_valid or ld.
- q = mem[rd_ptr] when q_valid, else 0. qinv = ~q always. opcode derives from q.
- push = in_valid & in_ready: mem[wr_ptr]<=d, wr_ptr+1.
- pop = ld & q_valid: rd_ptr+1.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: a word pushed at edge N into an empty queue appears on q, with q_valid=1, immediately after edge N.
- Full (count==DEPTH): in_ready=0, push blocked even if ld=1 that cycle. The pop still occurs and in_ready returns to 1 the next cycle.
- Empty: ld ignored (no pop, no pointer change). A simultaneous push still occurs.
- Simultaneous push and pop with 0<count<DEPTH: both occur, count unchanged.
- in_valid held with in_ready=0: the word is not captured; the source holds it.
- Priority: rst > flush > push/pop.
- flush=1: wr_ptr=0, rd_ptr=0, count=0. Any push or pop that cycle is dropped. q_valid=0 the next cycle.
- Reset mid-stream behaves identically to flush.

Optional Feature:
- Macro: IR_PARITY_EN.
- Defined:
  - Each entry stores an extra even-parity bit (^d) computed at push.
  - Extra input perr_inject (1 bit): when high during a push, the stored parity bit is inverted.
  - Extra output parity_err (1 bit) = q_valid & (^q != stored parity of head); 0 after reset and flush.
  - Queue operation is otherwise unchanged.
- Not defined: no parity storage, no perr_inject or parity_err ports.

Test Plan:
- Reset, then push 16'hA5C3 with in_valid=1, ld=0 -> next cycle q=16'hA5C3, qinv=16'h5A3C, opcode=4'hA, q_valid=1, count=1.
- Push 16'h1111, 16'h2222, 16'h3333, 16'h4444 with no ld -> count=4, in_ready=0; push of 16'h5555 while full is dropped; four ld pulses return 1111, 2222, 3333, 4444 in order, then q_valid=0, q=0.
- With count=2, assert in_valid and ld together for 6 cycles (words 16'h0001..16'h0006) -> count stays 2; q sequence follows FIFO order across pointer wrap.
- Full queue, ld=1 and in_valid=1 same cycle -> pop only: count 4->3, pushed word not captured, in_ready=1 next cycle.
- Queue holds 3 words; flush=1 with in_valid=1, d=16'hBEEF -> next cycle count=0, q_valid=0. A subsequent push of 16'hCAFE appears as head, proving BEEF was dropped.
- IR_PARITY_EN: push 16'h0F0F with perr_inject=1, then 16'h0F0F with perr_inject=0 -> parity_err=1 on the first head, 0 after ld; rst -> parity_err=0.
